shift_load_arbiter: RTL and testbench
=====================================

Name: shift_load_arbiter

Overview:
- Shares one serial shift-register chain between two requesters.
- Each requester holds a parallel word; the block grants one requester at a time using round-robin arbitration.
- It serialises the granted word LSB-first onto serial_out and emits a shift_en strobe at a divided rate. shift_en feeds the chain's enable.
- After WIDTH strobes the word sits fully in the downstream chain, and the block pulses done.

Parameters:
- WIDTH, 16, bits per word and number of shift strobes per transfer.
- DIV, 25000000, clk_100MHz cycles between shift strobes (4 Hz at 100 MHz). Legal range is >= 1.
- CNT_W, $clog2(DIV+1), width of the tick counter. Derived; never overridden.

Ports:
- clk_100MHz  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  2  level request per requester. Held high until that requester sees done with its id.
- data0  in  WIDTH  word from requester 0. Sampled only on its grant cycle.
- data1  in  WIDTH  word from requester 1. Sampled only on its grant cycle.
- grant  out  2  one-hot current owner. 0 when idle.
- busy  out  1  high while a transfer is in progress.
- serial_out  out  1  current bit to shift into the chain.
- shift_en  out  1  single-cycle strobe. The chain shifts serial_out in on this cycle.
- done  out  1  single-cycle completion pulse.
- done_id  out  1  index of the finished requester, valid when done=1.
- latch_pulse  out  1  see Optional Feature.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - grant=0, busy=0, serial_out=0, shift_en=0, done=0, done_id=0, latch_pulse=0.
  - Shadow register=0, bit counter=0, tick counter=DIV-1, last-served pointer=1.
- The last-served pointer resets to 1, so requester 0 wins the first contention.
- All outputs are registered.
- Reset asserted mid-transfer aborts immediately with no done.
- FSM states are IDLE, SHIFT, DONE.
- IDLE:
  - If req!=0, select the winner.
    - If only one requester is active, it wins.
    - If both are active, the winner is the requester not equal to the last-served pointer.
  - Next cycle: grant=onehot(winner), busy=1, shadow=data_winner, bit counter=0, tick counter=DIV-1, state=SHIFT.
  - serial_out=shadow[0] from that cycle onward.
- SHIFT:
  - The tick counter decrements each cycle.
  - When the tick counter is 0:
    - shift_en=1 for that cycle, with serial_out still holding the current bit.
    - On the next edge: shadow shifts right by 1, the bit counter increments, and the tick counter reloads to DIV-1.
  - The first shift_en occurs DIV cycles after SHIFT entry. Consecutive strobes are DIV cycles apart.
  - With DIV=1, shift_en is high on every SHIFT cycle.
  - When the strobe with bit counter=WIDTH-1 fires, the next state is DONE.
- DONE (exactly one cycle):
  - done=1, done_id=winner, busy=0, grant=0.
  - The last-served pointer updates to winner.
  - The next state is IDLE.
- Requester protocol:
  - Deasserting req during SHIFT is ignored; the transfer always completes and data changes have no effect after the grant.
  - If the served requester's req is still high in the IDLE cycle after DONE, it competes normally. Round-robin then favours the other requester if both are active.
- Minimum transfer latency, from req high in IDLE to done: 1 + WIDTH*DIV + 1 cycles.
- Bit order: LSB first. A right-shifting chain fed at its MSB holds the exact word after WIDTH strobes.

Optional Feature:
- Macro: SHIFT_LATCH_STROBE_EN.
- Defined:
  - latch_pulse=1 for one cycle, coincident with done.
  - Lets downstream logic copy the chain contents to its display/output register atomically.
- Undefined:
  - latch_pulse is tied to 0.
  - No extra flops; all other timing is identical.

Decomposition:
- Shared package shift_pkg holds:
  - State encoding: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Constants REQ_N=2 and DEFAULT_DIV=25000000.
- One natural sub-module: rr_arbiter2, combinational winner select from req and the last-served pointer.
- Tick counter and shadow register remain inline.

Test Plan (WIDTH=8, DIV=4):
- Single request: req=2'b01, data0=8'hA5.
  - grant=01 one cycle later.
  - shift_en fires 8 times, 4 cycles apart.
  - serial_out sequence at the strobes is 1,0,1,0,0,1,0,1.
  - done=1, done_id=0 at cycle 1+32+1=34.
- Contention from reset: req=2'b11 in IDLE.
  - Requester 0 is served first.
  - With req held at 11, requester 1 is served next.
  - Then requester 0 again (round-robin alternates).
- Mid-transfer interference: drop req0 and change data0 after 3 strobes.
  - The remaining 5 bits still come from the original word.
  - done still pulses.
- Reset mid-shift: assert rst_n=0 after 5 strobes.
  - All outputs are immediately 0, with no done.
  - After release, a new req restarts from bit 0.
- DIV=1 corner: shift_en is high on 8 consecutive cycles, and done follows on the next cycle.
- With SHIFT_LATCH_STROBE_EN defined, latch_pulse equals done on every transfer. Undefined, it stays 0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared state encoding, constants and helpers for the shift_load_arbiter slice.
`timescale 1ns/1ps
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int REQ_N       = 2;
  localparam int DEFAULT_DIV = 25000000;

  function automatic logic [REQ_N-1:0] onehot2(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shift_load_arbiter_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin winner select.
`timescale 1ns/1ps
module rr_arbiter2
  import shift_pkg::*;
(
  input  logic [REQ_N-1:0] req,
  input  logic             last_served,
  output logic             valid,
  output logic             winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      // On contention the requester not served last time wins.
      2'b11:   winner = ~last_served;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_load_arbiter.sv
// Round-robin owner of one serial shift chain; serialises the granted word LSB-first.
// Optional latch strobe coincident with done: define SHIFT_LATCH_STROBE_EN.
`timescale 1ns/1ps
module shift_load_arbiter
  import shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIV   = DEFAULT_DIV
) (
  input  logic             clk_100MHz,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [REQ_N-1:0] grant,
  output logic             busy,
  output logic             serial_out,
  output logic             shift_en,
  output logic             done,
  output logic             done_id,
  output logic             latch_pulse
);

  localparam int CNT_W = $clog2(DIV + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] TICK_RELOAD = CNT_W'(DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(WIDTH - 1);
  localparam logic             STROBE_ON_ENTRY = (DIV == 1);

  state_t           state;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_shr;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] tick;
  logic             last_served;
  logic             owner;
  logic             arb_valid;
  logic             arb_winner;
  logic [WIDTH-1:0] win_data;
  logic             last_strobe;

  rr_arbiter2 u_arb (
    .req         (req),
    .last_served (last_served),
    .valid       (arb_valid),
    .winner      (arb_winner)
  );

  assign win_data    = arb_winner ? data1 : data0;
  assign shadow_shr  = shadow >> 1;
  assign last_strobe = (state == SHIFT) && (tick == '0) && (bit_cnt == LAST_BIT);

  // shift_en is registered, so it is raised on the edge where tick reaches 0
  // to land in the same cycle the counter reads 0.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      serial_out  <= 1'b0;
      shift_en    <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      shadow      <= '0;
      bit_cnt     <= '0;
      tick        <= TICK_RELOAD;
      last_served <= 1'b1;
      owner       <= 1'b0;
    end else begin
      shift_en <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state      <= SHIFT;
            owner      <= arb_winner;
            grant      <= onehot2(arb_winner);
            busy       <= 1'b1;
            shadow     <= win_data;
            serial_out <= win_data[0];
            bit_cnt    <= '0;
            tick       <= TICK_RELOAD;
            shift_en   <= STROBE_ON_ENTRY;
          end
        end
        SHIFT: begin
          if (tick == '0) begin
            shadow     <= shadow_shr;
            serial_out <= shadow_shr[0];
            bit_cnt    <= bit_cnt + 1'b1;
            tick       <= TICK_RELOAD;
            if (bit_cnt == LAST_BIT) begin
              state       <= DONE;
              grant       <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
              done_id     <= owner;
              last_served <= owner;
            end else begin
              shift_en <= STROBE_ON_ENTRY;
            end
          end else begin
            tick     <= tick - 1'b1;
            shift_en <= (tick == CNT_W'(1));
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHIFT_LATCH_STROBE_EN
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      latch_pulse <= 1'b0;
    end else begin
      latch_pulse <= last_strobe;
    end
  end
`else
  assign latch_pulse = 1'b0;
  logic unused_last_strobe;
  assign unused_last_strobe = last_strobe;
`endif

endmodule

// File: tb/tb_shift_load_arbiter.sv
// Directed bench for shift_load_arbiter: WIDTH=8 at DIV=4 and DIV=1.
`timescale 1ns/1ps
module tb_shift_load_arbiter;

  localparam int W     = 8;
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

`ifdef SHIFT_LATCH_STROBE_EN
  localparam bit LATCH_EN = 1'b1;
`else
  localparam bit LATCH_EN = 1'b0;
`endif

  logic clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  logic         rst_n;
  logic [1:0]   req_a, req_b;
  logic [W-1:0] d0_a, d1_a, d0_b, d1_b;
  logic [1:0]   grant_a, grant_b;
  logic         busy_a, busy_b, ser_a, ser_b, sen_a, sen_b;
  logic         done_a, done_b, did_a, did_b, lat_a, lat_b;

  shift_load_arbiter #(.WIDTH(W), .DIV(DIV_A)) dut_a (
    .clk_100MHz (clk_100MHz), .rst_n (rst_n), .req (req_a),
    .data0 (d0_a), .data1 (d1_a), .grant (grant_a), .busy (busy_a),
    .serial_out (ser_a), .shift_en (sen_a), .done (done_a),
    .done_id (did_a), .latch_pulse (lat_a)
  );

  shift_load_arbiter #(.WIDTH(W), .DIV(DIV_B)) dut_b (
    .clk_100MHz (clk_100MHz), .rst_n (rst_n), .req (req_b),
    .data0 (d0_b), .data1 (d1_b), .grant (grant_b), .busy (busy_b),
    .serial_out (ser_b), .shift_en (sen_b), .done (done_b),
    .done_id (did_b), .latch_pulse (lat_b)
  );

  logic       which;
  logic [1:0] c_grant;
  logic       c_busy, c_ser, c_sen, c_done, c_did, c_lat;

  always_comb begin
    c_grant = which ? grant_b : grant_a;
    c_busy  = which ? busy_b  : busy_a;
    c_ser   = which ? ser_b   : ser_a;
    c_sen   = which ? sen_b   : sen_a;
    c_done  = which ? done_b  : done_a;
    c_did   = which ? did_b   : did_a;
    c_lat   = which ? lat_b   : lat_a;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic w, input logic [1:0] r, input logic [W-1:0] d0,
                       input logic [W-1:0] d1);
    if (w) begin
      req_b = r; d0_b = d0; d1_b = d1;
    end else begin
      req_a = r; d0_a = d0; d1_a = d1;
    end
  endtask

  // Called at a negedge with the DUT in IDLE. Cycle k=1 is the IDLE cycle in which
  // req is presented; strobes expected at k=1+div*n, done at k=2+W*div.
  task automatic xfer(input logic w, input logic [1:0] r, input logic [W-1:0] d0,
                      input logic [W-1:0] d1, input logic exp_id,
                      input logic [W-1:0] exp_word, input int mod_after,
                      input bit drop_req);
    int           div;
    int           last_k;
    bit           strobe;
    logic [W-1:0] chain;
    logic [1:0]   exp_grant;
    which     = w;
    div       = w ? DIV_B : DIV_A;
    last_k    = 2 + W * div;
    chain     = '0;
    exp_grant = exp_id ? 2'b10 : 2'b01;
    chk("idle_busy", {31'd0, c_busy}, 32'd0);
    drive(w, r, d0, d1);
    for (int k = 2; k <= last_k + 1; k++) begin
      @(negedge clk_100MHz);
      strobe = (k <= last_k - 1) && (((k - 1) % div) == 0);
      chk("shift_en", {31'd0, c_sen}, {31'd0, strobe});
      chk("done", {31'd0, c_done}, {31'd0, k == last_k});
      chk("latch_pulse", {31'd0, c_lat}, {31'd0, LATCH_EN && (k == last_k)});
      chk("busy", {31'd0, c_busy}, {31'd0, k < last_k});
      chk("grant", {30'd0, c_grant}, (k < last_k) ? {30'd0, exp_grant} : 32'd0);
      if (strobe) chain = {c_ser, chain[W-1:1]};
      if (k == last_k) begin
        chk("done_id", {31'd0, c_did}, {31'd0, exp_id});
        chk("word", {24'd0, chain}, {24'd0, exp_word});
        if (drop_req) drive(w, 2'b00, d0, d1);
      end
      if (mod_after > 0 && k == 1 + div * mod_after) drive(w, 2'b00, ~d0, d1);
    end
  endtask

  typedef struct {
    logic [1:0]   r;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         id;
    logic [W-1:0] word;
    int           mod_after;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{r: 2'b01, d0: 8'hA5, d1: 8'h00, id: 1'b0, word: 8'hA5, mod_after: 0};
    tbl[1] = '{r: 2'b10, d0: 8'hFF, d1: 8'h3C, id: 1'b1, word: 8'h3C, mod_after: 0};
    tbl[2] = '{r: 2'b01, d0: 8'hFF, d1: 8'h00, id: 1'b0, word: 8'hFF, mod_after: 0};
    tbl[3] = '{r: 2'b10, d0: 8'h80, d1: 8'h01, id: 1'b1, word: 8'h01, mod_after: 0};
    tbl[4] = '{r: 2'b01, d0: 8'h5A, d1: 8'hC3, id: 1'b0, word: 8'h5A, mod_after: 3};

    which = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, 2'b00, '0, '0);
    drive(1'b1, 2'b00, '0, '0);
    #1;
    chk("rst_a_outs", {24'd0, grant_a, busy_a, ser_a, sen_a, done_a, did_a, lat_a}, 32'd0);
    chk("rst_b_outs", {24'd0, grant_b, busy_b, ser_b, sen_b, done_b, did_b, lat_b}, 32'd0);
    repeat (2) @(negedge clk_100MHz);
    rst_n = 1'b1;
    @(negedge clk_100MHz);

    for (int i = 0; i < 5; i++)
      xfer(1'b0, tbl[i].r, tbl[i].d0, tbl[i].d1, tbl[i].id, tbl[i].word,
           tbl[i].mod_after, 1'b1);

    // Reset in the middle of the fifth strobe cycle.
    which = 1'b0;
    drive(1'b0, 2'b10, 8'h00, 8'hF0);
    for (int k = 2; k <= 1 + DIV_A * 5; k++) @(negedge clk_100MHz);
    chk("pre_rst_serial", {31'd0, ser_a}, 32'd1);
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    #1;
    chk("midrst_outs", {24'd0, grant_a, busy_a, ser_a, sen_a, done_a, did_a, lat_a}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_100MHz);
      chk("midrst_no_done", {31'd0, done_a}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk_100MHz);
    chk("post_rst_busy", {31'd0, busy_a}, 32'd0);
    xfer(1'b0, 2'b10, 8'h00, 8'h96, 1'b1, 8'h96, 0, 1'b1);

    // Contention with req held at 11: pointer is 1 after reset, so 0, 1, 0.
    xfer(1'b0, 2'b11, 8'hE7, 8'h18, 1'b0, 8'hE7, 0, 1'b0);
    xfer(1'b0, 2'b11, 8'hE7, 8'h18, 1'b1, 8'h18, 0, 1'b0);
    xfer(1'b0, 2'b11, 8'hE7, 8'h18, 1'b0, 8'hE7, 0, 1'b1);

    // DIV=1: eight back-to-back strobes, done on the following cycle.
    xfer(1'b1, 2'b01, 8'h6B, 8'h00, 1'b0, 8'h6B, 0, 1'b1);
    xfer(1'b1, 2'b10, 8'h00, 8'hD4, 1'b1, 8'hD4, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
